// File: rtl/output_bridge_multi_port_if.sv
// Bundles the core-side and host-side signals of output_bridge_multi_port.
// master: the environment (core network + host); slave: the bridge itself.
interface output_bridge_multi_port_if #(
    parameter int NUM_CH     = 20,
    parameter int NUM_RD     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = $clog2(NUM_CH)
);
    logic [NUM_CH*(DATA_WIDTH+1)-1:0] d_in;
    logic [NUM_CH-1:0]                c_out;
    logic [NUM_RD*CH_W-1:0]           port;
    logic [NUM_RD-1:0]                rd_en;
    logic                             conf_en;
    logic [NUM_RD*DATA_WIDTH-1:0]     d_out;
    logic [NUM_RD-1:0]                done;

    modport master (
        output d_in, port, rd_en, conf_en,
        input  c_out, d_out, done
    );

    modport slave (
        input  d_in, port, rd_en, conf_en,
        output c_out, d_out, done
    );
endinterface

// File: rtl/output_bridge_multi_port.sv
// output_bridge_multi_port: per-channel FIFOs between the core output network
// and NUM_RD host read ports, with fixed-priority (lowest port wins) pop
// arbitration, registered done/d_out strobes and per-pop credit return.
// Optional macro OB_OVF_CHECK_EN adds the sticky per-channel ovf_err output.
module output_bridge_multi_port #(
    parameter int NUM_CH     = 20,
    parameter int NUM_RD     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    output_bridge_multi_port_if.slave bus
`ifdef OB_OVF_CHECK_EN
    ,
    output logic [NUM_CH-1:0]         ovf_err
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem    [NUM_CH][DEPTH];
    logic [PW-1:0]         wr_ptr [NUM_CH];
    logic [PW-1:0]         rd_ptr [NUM_CH];

    logic [NUM_CH-1:0]     in_valid;
    logic [DATA_WIDTH-1:0] in_data [NUM_CH];
    logic [NUM_CH-1:0]     empty;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     push;

    logic [CH_W-1:0]       sel  [NUM_RD];
    logic [DATA_WIDTH-1:0] head [NUM_RD];
    logic [NUM_RD-1:0]     sel_ok;
    logic [NUM_RD-1:0]     sel_empty;
    logic [NUM_RD-1:0]     blocked;
    logic [NUM_RD-1:0]     win;

    logic [NUM_CH-1:0]            c_out_q;
    logic [NUM_RD-1:0]            done_q;
    logic [NUM_RD*DATA_WIDTH-1:0] d_out_q;

    // Unpack the core bus and derive empty/full from the wrapping pointers.
    always_comb begin
        in_valid = '0;
        empty    = '0;
        full     = '0;
        in_data  = '{default: '0};
        for (int c = 0; c < NUM_CH; c++) begin
            in_valid[c] = bus.d_in[c*(DATA_WIDTH+1) + DATA_WIDTH];
            in_data[c]  = bus.d_in[c*(DATA_WIDTH+1) +: DATA_WIDTH];
            empty[c]    = (wr_ptr[c] == rd_ptr[c]);
            full[c]     = (wr_ptr[c][PW-1] != rd_ptr[c][PW-1]) &&
                          (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
        end
    end

    // Per read port: resolve its channel, and win only if no lower port asks for it.
    always_comb begin
        win       = '0;
        sel_ok    = '0;
        sel_empty = '1;
        blocked   = '0;
        sel       = '{default: '0};
        head      = '{default: '0};
        for (int r = 0; r < NUM_RD; r++) begin
            sel[r] = bus.port[r*CH_W +: CH_W];
        end
        for (int r = 0; r < NUM_RD; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel[r] == CH_W'(c)) begin
                    sel_ok[r]    = 1'b1;
                    sel_empty[r] = empty[c];
                    head[r]      = mem[c][rd_ptr[c][AW-1:0]];
                end
            end
            for (int q = 0; q < r; q++) begin
                if (bus.rd_en[q] && (sel[q] == sel[r])) begin
                    blocked[r] = 1'b1;
                end
            end
            win[r] = bus.rd_en[r] && sel_ok[r] && !sel_empty[r] &&
                     !blocked[r] && !bus.conf_en;
        end
    end

    // Collapse port wins onto channels; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        pop  = '0;
        push = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (win[r] && (sel[r] == CH_W'(c))) begin
                    pop[c] = 1'b1;
                end
            end
            push[c] = in_valid[c] && (!full[c] || pop[c]) && !bus.conf_en;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c][AW-1:0]] <= in_data[c];
            end
        end
    end

    // Pointer advance and registered pop results; conf_en flushes without credits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            c_out_q <= '0;
            done_q  <= '0;
            d_out_q <= '0;
        end else if (bus.conf_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            c_out_q <= '0;
            done_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                end
            end
            c_out_q <= pop;
            done_q  <= win;
            for (int r = 0; r < NUM_RD; r++) begin
                if (win[r]) begin
                    d_out_q[r*DATA_WIDTH +: DATA_WIDTH] <= head[r];
                end
            end
        end
    end

`ifdef OB_OVF_CHECK_EN
    logic [NUM_CH-1:0] ovf_q;

    // Sticky flag for a valid word that arrived at a full FIFO with no pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
        end else if (bus.conf_en) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | (in_valid & full & ~pop);
        end
    end

    assign ovf_err = ovf_q;
`endif

    assign bus.c_out = c_out_q;
    assign bus.done  = done_q;
    assign bus.d_out = d_out_q;
endmodule

// File: doc/output_bridge_multi_port.md
# output_bridge_multi_port

Parametrised successor to the dual-port output bridge. It sits between the core's output data network and the host receive interface. Each core output channel feeds its own FIFO, with credit return to the core. Any number of host read ports can each select a channel, pop one word and get a registered `done` strobe. The channel count, read-port count, data width and FIFO depth are all parameters, and fixed-priority arbitration handles read-port collisions.

## Interface
Parameters:
- `NUM_CH`, 20: number of core output channels.
- `NUM_RD`, 2: number of host read ports.
- `DATA_WIDTH`, 32: payload bits per word; the core bus adds one valid bit (MSB).
- `DEPTH`, 4: FIFO entries per channel; must be a power of two and at least 2.
- `CH_W`, `$clog2(NUM_CH)`: channel-select width (derived).

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `d_in`, in, `NUM_CH*(DATA_WIDTH+1)`: per-channel core words; bit `DATA_WIDTH` of each slice is valid.
- `c_out`, out, `NUM_CH`: per-channel credit pulse to the core, one per popped entry.
- `port`, in, `NUM_RD*CH_W`: per-read-port channel select.
- `rd_en`, in, `NUM_RD`: per-read-port pop request.
- `conf_en`, in, 1: configuration mode; flushes the block.
- `d_out`, out, `NUM_RD*DATA_WIDTH`: per-read-port popped payload.
- `done`, out, `NUM_RD`: per-read-port one-cycle strobe marking the pop as successful.
- `ovf_err`, out, `NUM_CH`: sticky per-channel overflow flag; present only with the macro (see Configuration).

## Operation
- Each channel has a circular FIFO with `DEPTH` entries. Read and write pointers are `log2(DEPTH)+1` bits, wrapping naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- Push: at each edge, a channel whose slice has valid=1 writes its payload if the FIFO is not full, or is full and is popped in the same cycle.
- Pop arbitration: in each cycle, each channel grants to the lowest-numbered read port that has `rd_en`=1 and selects it.
  - The grant takes effect only if the FIFO holds at least one entry at the start of the cycle. There is no write-through: a push into an empty FIFO cannot be popped in the same cycle.
  - Losing ports and ports that request an empty FIFO get `done`=0 and retry by holding `rd_en`.
  - A `port` value of `NUM_CH` or greater never pops, and `done` stays 0.
- Each successful pop drives three registered results on the next cycle:
  - the head payload on `d_out` for that port;
  - `done`=1 for that port;
  - `c_out`=1 for that channel.
- When a port does not pop, its `d_out` holds its previous value and its `done` is 0.
- `conf_en`=1 flushes the block at every edge while it is high:
  - all pointers are cleared;
  - pushes and pops are ignored;
  - `done`, `c_out` and `ovf_err` are forced to 0.
  - No credits are returned for flushed entries, because the core resets its own credit counters under `conf_en`.
- Reset values: all FIFOs empty, `d_out`=0, `done`=0, `c_out`=0, `ovf_err`=0.
- Reset mid-operation clears everything immediately (asynchronous), and pending strobes are lost.

## Timing
- Push to poppable: a word pushed at edge N can be popped by a request sampled at edge N+1 at the earliest, with `done` high in the cycle after edge N+1.
- Pop request to `done` and `d_out`: 1 cycle.
- Pop to `c_out`: 1 cycle, coincident with `done`.
- Back-to-back pops from one channel by one port: sustained at 1 word per cycle while the FIFO is non-empty.
- Two ports may pop different channels in the same cycle with no penalty.
- Two ports selecting the same channel: only one pop per channel per cycle. The higher-numbered port gets a pop one cycle later, at the earliest.
- The host combines stalls itself, as `rd_en & ~done`. The block contains no combinational path from `rd_en` to `done`.

## Configuration
- `OB_OVF_CHECK_EN` defined:
  - the `ovf_err` port exists;
  - a push to a full FIFO with no simultaneous pop drops the word and sets `ovf_err[ch]`;
  - the flag is cleared only by `rst` or `conf_en`.
- `OB_OVF_CHECK_EN` undefined:
  - the `ovf_err` port is absent;
  - an overflowing push is dropped silently.
- FIFO behaviour is otherwise identical with and without the macro.

## Test plan
- Reset, then push `0xA5` on channel 3, then request port0=3 with `rd_en0`=1 held for 2 cycles: `done0` pulses exactly once, `d_out0`=`0xA5`, `c_out[3]` pulses once, and the second request gets `done0`=0.
- Fill channel 7 with 4 words (1..4), then pop with port1 on 4 consecutive cycles: `d_out1` reads 1, 2, 3, 4 on consecutive cycles, `done1` is high for 4 cycles, and `c_out[7]` pulses 4 times.
- Channel 5 holds 1 word and both ports select 5 in the same cycle: port0 gets `done`=1, port1 gets `done`=0; after a second push, port1 succeeds on its retry.
- Full channel 2 (`DEPTH`=4) receives a push and a pop in the same cycle: count stays 4, no `ovf_err`, and the popped word is the oldest. With `OB_OVF_CHECK_EN` defined, a push to the full channel without a pop sets `ovf_err[2]` and the word is lost.
- Push to empty channel 0 and pop it in the same cycle: `done`=0. The pop on the next cycle succeeds.
- Load 3 channels, assert `conf_en` for 1 cycle: all pops afterwards return `done`=0, and no `c_out` pulses appear. Assert `rst` low mid-pop: `done`, `c_out` and `d_out` go to 0 immediately.
